// File: rtl/cordic_bus_pkg.sv
// Shared definitions for the CORDIC host bus bridge: register map, control/IRQ
// bit positions and the bridge FSM state type.
package cordic_bus_pkg;

    localparam logic [4:0] OFF_X    = 5'h00;
    localparam logic [4:0] OFF_Y    = 5'h04;
    localparam logic [4:0] OFF_Z    = 5'h08;
    localparam logic [4:0] OFF_CTRL = 5'h0C;
    localparam logic [4:0] OFF_XRES = 5'h10;
    localparam logic [4:0] OFF_YRES = 5'h14;
    localparam logic [4:0] OFF_ZRES = 5'h18;
    localparam logic [4:0] OFF_IRQ  = 5'h1C;

    localparam int CTRL_START      = 0;
    localparam int CTRL_STOP       = 1;
    localparam int CTRL_READY_FLAG = 16;
    localparam int CTRL_HOST_BITS  = 16;

    localparam int IRQ_PENDING = 0;
    localparam int IRQ_ENABLE  = 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} bridge_state_t;

    // Result registers are read-only from the host side.
    function automatic logic is_result_reg(input logic [4:0] addr);
        return (addr == OFF_XRES) || (addr == OFF_YRES) || (addr == OFF_ZRES);
    endfunction

endpackage

// File: rtl/cordic_bus_bridge.sv
// APB-style register slave fronting the CORDIC controller: operand/control
// shadow registers, result capture and a sticky, maskable host interrupt.
module cordic_bus_bridge
    import cordic_bus_pkg::*;
#(
    parameter int p_WIDTH      = 32,
    parameter int p_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [p_ADDR_WIDTH-1:0]   paddr,
    input  logic [p_WIDTH-1:0]        pwdata,
    output logic                      pready,
    output logic [p_WIDTH-1:0]        prdata,
    output logic                      pslverr,
    output logic                      irqOut,
    output logic signed [p_WIDTH-1:0] xInput,
    output logic signed [p_WIDTH-1:0] yInput,
    output logic signed [p_WIDTH-1:0] zInput,
    output logic [p_WIDTH-1:0]        controlRegisterInput,
    input  logic signed [p_WIDTH-1:0] xResult,
    input  logic signed [p_WIDTH-1:0] yResult,
    input  logic signed [p_WIDTH-1:0] zResult,
    input  logic [p_WIDTH-1:0]        controlRegisterOutput,
    input  logic                      controlRegisterWriteEnable,
    input  logic                      interrupt
);

    bridge_state_t             state;
    logic [p_ADDR_WIDTH-1:0]   addr_q;
    logic                      write_q;
    logic [p_WIDTH-1:0]        wdata_q;

    logic signed [p_WIDTH-1:0] x_reg, y_reg, z_reg;
    logic signed [p_WIDTH-1:0] xres_reg, yres_reg, zres_reg;
    logic [p_WIDTH-1:0]        ctrl_reg;
    logic                      capture_q;
    logic                      irq_prev;
    logic                      pending;
    logic                      enable_q;

    logic                      access_err;
    logic                      commit;
    logic                      hit_x, hit_y, hit_z, hit_ctrl, hit_irq;
    logic                      ready_rise;
    logic                      irq_rise;
    logic                      pending_next;
    logic [p_WIDTH-1:0]        ctrl_next;
    logic [p_WIDTH-1:0]        read_data;

    assign xInput               = x_reg;
    assign yInput               = y_reg;
    assign zInput               = z_reg;
    assign controlRegisterInput = ctrl_reg;

    always_comb begin
        access_err = (addr_q[1:0] != 2'b00) || (write_q && is_result_reg(addr_q));
        commit     = (state == WAIT) && psel && write_q && !access_err;
        hit_x      = commit && (addr_q == OFF_X);
        hit_y      = commit && (addr_q == OFF_Y);
        hit_z      = commit && (addr_q == OFF_Z);
        hit_ctrl   = commit && (addr_q == OFF_CTRL);
        hit_irq    = commit && (addr_q == OFF_IRQ);

        ready_rise = controlRegisterWriteEnable
                   && controlRegisterOutput[CTRL_READY_FLAG]
                   && !ctrl_reg[CTRL_READY_FLAG];
        irq_rise   = interrupt && !irq_prev;

        // Start/stop self-clear; the core owns the flags, the host owns the low half.
        ctrl_next = ctrl_reg;
        ctrl_next[CTRL_START] = 1'b0;
        ctrl_next[CTRL_STOP]  = 1'b0;
        if (controlRegisterWriteEnable)
            ctrl_next = controlRegisterOutput;
        if (hit_ctrl)
            ctrl_next[CTRL_HOST_BITS-1:0] = wdata_q[CTRL_HOST_BITS-1:0];

        pending_next = pending;
        if (hit_irq && wdata_q[IRQ_PENDING])
            pending_next = 1'b0;
        if (irq_rise)
            pending_next = 1'b1;

        read_data = '0;
        case (addr_q)
            OFF_X:    read_data = x_reg;
            OFF_Y:    read_data = y_reg;
            OFF_Z:    read_data = z_reg;
            OFF_CTRL: read_data = ctrl_reg;
            OFF_XRES: read_data = xres_reg;
            OFF_YRES: read_data = yres_reg;
            OFF_ZRES: read_data = zres_reg;
            OFF_IRQ: begin
                read_data[IRQ_PENDING] = pending;
                read_data[IRQ_ENABLE]  = enable_q;
            end
            default:  read_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    prdata  <= '0;
                    pslverr <= 1'b0;
                    if (psel && !penable) begin
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else begin
                        state   <= RESP;
                        pready  <= 1'b1;
                        pslverr <= access_err;
                        prdata  <= (access_err || write_q) ? '0 : read_data;
                    end
                end
                RESP: begin
                    pready  <= 1'b0;
                    prdata  <= '0;
                    pslverr <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Results are taken one cycle after the core raises its ready flag and then held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            ctrl_reg  <= '0;
            xres_reg  <= '0;
            yres_reg  <= '0;
            zres_reg  <= '0;
            capture_q <= 1'b0;
            irq_prev  <= 1'b0;
            pending   <= 1'b0;
            enable_q  <= 1'b0;
            irqOut    <= 1'b0;
        end else begin
            if (hit_x) x_reg <= wdata_q;
            if (hit_y) y_reg <= wdata_q;
            if (hit_z) z_reg <= wdata_q;
            ctrl_reg  <= ctrl_next;
            capture_q <= ready_rise;
            if (capture_q) begin
                xres_reg <= xResult;
                yres_reg <= yResult;
                zres_reg <= zResult;
            end
            irq_prev <= interrupt;
            pending  <= pending_next;
            if (hit_irq) enable_q <= wdata_q[IRQ_ENABLE];
            irqOut   <= pending && enable_q;
        end
    end

endmodule

// File: tb/tb_cordic_bus_bridge.sv
// Directed bench for cordic_bus_bridge: a register-access vector table plus
// hand sequences for self-clearing control, result capture, interrupts, abort and reset.
module tb_cordic_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        irqOut;
    logic signed [31:0] xInput, yInput, zInput;
    logic [31:0] controlRegisterInput;
    logic signed [31:0] xResult, yResult, zResult;
    logic [31:0] controlRegisterOutput;
    logic        controlRegisterWriteEnable;
    logic        interrupt;

    int checks = 0;
    int errors = 0;

    logic [31:0] resp_x;
    logic [31:0] resp_ctrl;

    typedef struct {
        logic [4:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    cordic_bus_bridge dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .irqOut(irqOut),
        .xInput(xInput), .yInput(yInput), .zInput(zInput),
        .controlRegisterInput(controlRegisterInput),
        .xResult(xResult), .yResult(yResult), .zResult(zResult),
        .controlRegisterOutput(controlRegisterOutput),
        .controlRegisterWriteEnable(controlRegisterWriteEnable),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Full transfer starting just after a rising edge; returns latency in access cycles.
    task automatic apply_stimulus(input logic [4:0] addr, input logic write,
                                  input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err,
                                  output int lat);
        bit got = 0;
        rdata = '0; err = 1'b0; lat = 0;
        psel = 1'b1; penable = 1'b0; pwrite = write; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (pready) begin
                got = 1; lat = i;
                rdata = prdata; err = pslverr;
                resp_x = xInput; resp_ctrl = controlRegisterInput;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL pready_timeout actual=0 expected=1 addr=%h", addr);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [4:0] addr,
                           input logic [31:0] expected);
        logic [31:0] rd; logic er; int lt;
        apply_stimulus(addr, 1'b0, 32'h0, rd, er, lt);
        check_output({name, "_data"}, rd, expected);
        check_output({name, "_err"}, {31'b0, er}, 32'h0);
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        logic [31:0] rd; logic er; int lt;
        apply_stimulus(addr, 1'b1, data, rd, er, lt);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        bit          saw_ready;

        rst = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        xResult = '0; yResult = '0; zResult = '0;
        controlRegisterOutput = '0; controlRegisterWriteEnable = 0; interrupt = 0;

        vecs.push_back('{5'h00, 1'b0, 32'h0,         32'h0000_1234, 1'b0});
        vecs.push_back('{5'h04, 1'b1, 32'hCAFE_0001, 32'h0,         1'b0});
        vecs.push_back('{5'h04, 1'b0, 32'h0,         32'hCAFE_0001, 1'b0});
        vecs.push_back('{5'h08, 1'b1, 32'h8000_0000, 32'h0,         1'b0});
        vecs.push_back('{5'h08, 1'b0, 32'h0,         32'h8000_0000, 1'b0});
        vecs.push_back('{5'h0C, 1'b1, 32'hABCD_0104, 32'h0,         1'b0});
        vecs.push_back('{5'h0C, 1'b0, 32'h0,         32'h0000_0104, 1'b0});
        vecs.push_back('{5'h10, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b1});
        vecs.push_back('{5'h06, 1'b0, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{5'h10, 1'b0, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{5'h14, 1'b1, 32'h0000_0001, 32'h0,         1'b1});
        vecs.push_back('{5'h18, 1'b1, 32'h0000_0001, 32'h0,         1'b1});
        vecs.push_back('{5'h03, 1'b1, 32'h0000_0055, 32'h0,         1'b1});
        vecs.push_back('{5'h00, 1'b0, 32'h0,         32'h0000_1234, 1'b0});
        vecs.push_back('{5'h1C, 1'b1, 32'hFFFF_FFFE, 32'h0,         1'b0});
        vecs.push_back('{5'h1C, 1'b0, 32'h0,         32'h0000_0002, 1'b0});
        vecs.push_back('{5'h14, 1'b0, 32'h0,         32'h0,         1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_pready",  {31'b0, pready},  32'h0);
        check_output("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check_output("rst_prdata",  prdata,           32'h0);
        check_output("rst_irqOut",  {31'b0, irqOut},  32'h0);
        check_output("rst_xInput",  xInput,           32'h0);
        check_output("rst_ctrl",    controlRegisterInput, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] X write latency and visibility");
        apply_stimulus(5'h00, 1'b1, 32'h0000_1234, rd, er, lt);
        check_output("x_wr_latency", lt, 2);
        check_output("x_wr_err",     {31'b0, er}, 32'h0);
        check_output("x_at_resp",    resp_x, 32'h0000_1234);

        $display("[TB] register table");
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].addr, vecs[i].write, vecs[i].wdata, rd, er, lt);
            check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check_output($sformatf("vec%0d_latency", i), lt, 2);
        end
        check_output("xres_after_ro_write", dut.xres_reg, 32'h0);

        $display("[TB] control start self-clear");
        do_write(5'h0C, 32'h0000_0105);
        check_output("ctrl_start_at_resp", {31'b0, resp_ctrl[0]}, 32'h1);
        @(negedge clk);
        check_output("ctrl_start_cleared", {31'b0, controlRegisterInput[0]}, 32'h0);
        check_output("ctrl_bits_12_8", {27'b0, controlRegisterInput[12:8]}, 32'h1);
        check_output("ctrl_bit2", {31'b0, controlRegisterInput[2]}, 32'h1);
        @(posedge clk); #1;
        do_read("ctrl_readback", 5'h0C, 32'h0000_0104);

        $display("[TB] result capture");
        xResult = 32'h7FFF_0000; yResult = 32'h0000_00AA; zResult = 32'hFFFF_FFFF;
        controlRegisterOutput = 32'h0001_0000; controlRegisterWriteEnable = 1'b1;
        @(posedge clk); #1;
        controlRegisterWriteEnable = 1'b0;
        repeat (2) @(posedge clk); #1;
        xResult = 32'h1111_1111;
        do_read("xres", 5'h10, 32'h7FFF_0000);
        do_read("yres", 5'h14, 32'h0000_00AA);
        do_read("zres", 5'h18, 32'hFFFF_FFFF);
        do_read("ctrl_flag", 5'h0C, 32'h0001_0000);
        controlRegisterWriteEnable = 1'b1;
        @(posedge clk); #1;
        controlRegisterWriteEnable = 1'b0;
        repeat (3) @(posedge clk); #1;
        do_read("xres_no_edge", 5'h10, 32'h7FFF_0000);

        $display("[TB] interrupt");
        interrupt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("irqOut_set", {31'b0, irqOut}, 32'h1);
        @(posedge clk); #1;
        do_read("irq_pending", 5'h1C, 32'h0000_0003);
        interrupt = 1'b0;
        repeat (2) @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h1C; pwdata = 32'h3;
        @(posedge clk); #1;
        penable = 1'b1; interrupt = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        do_read("irq_set_wins", 5'h1C, 32'h0000_0003);
        do_write(5'h1C, 32'h0000_0003);
        do_read("irq_cleared", 5'h1C, 32'h0000_0002);
        @(negedge clk);
        check_output("irqOut_cleared", {31'b0, irqOut}, 32'h0);
        @(posedge clk); #1;
        interrupt = 1'b0;

        $display("[TB] abort in wait state");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'h1111_1111;
        @(posedge clk); #1;
        psel = 1'b0; pwrite = 1'b0;
        saw_ready = 0;
        repeat (4) begin
            @(negedge clk);
            if (pready) saw_ready = 1;
        end
        check_output("abort_no_pready", {31'b0, saw_ready}, 32'h0);
        check_output("abort_yInput", yInput, 32'hCAFE_0001);
        @(posedge clk); #1;
        do_read("abort_y_readback", 5'h04, 32'hCAFE_0001);

        $display("[TB] reset in wait state");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'h2222_2222;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        check_output("rstwait_pready", {31'b0, pready}, 32'h0);
        check_output("rstwait_yInput", yInput, 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst = 1'b1;
        saw_ready = 0;
        repeat (4) begin
            @(negedge clk);
            if (pready) saw_ready = 1;
        end
        check_output("rstwait_no_pready", {31'b0, saw_ready}, 32'h0);
        @(posedge clk); #1;
        do_read("rstwait_y", 5'h04, 32'h0);
        do_read("rstwait_x", 5'h00, 32'h0);
        do_write(5'h04, 32'h0000_0042);
        do_read("post_reset_y", 5'h04, 32'h0000_0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
